clock_phase_gen: RTL

- Upstream of the top-level processor wrapper. Generates the four derived clocks from the single master `clock`: processor_clock, imem_clock, dmem_clock and regfile_clock.
- Each output is a registered, glitch-free waveform. It is defined by a programmable high-window within a PERIOD-cycle phase counter.
- Adds run/single-step control so a bench or debug host can stop, start or advance the processor one period at a time.

---
 rtl/clock_phase_gen.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/clock_phase_gen.sv
// clock_phase_gen: derives processor/imem/dmem/regfile clocks from the master
// clock as programmable high-windows inside a PERIOD-cycle phase counter, with
// run / single-step control.
// Optional feature: define CLOCK_PHASE_CYCLE_COUNT_EN to add a 32-bit
// completed-period counter output (cycle_count).
module clock_phase_gen #(
    parameter int PERIOD = 8,
    parameter int PW     = 3
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          run,
    input  logic          step_req,
    input  logic [PW-1:0] cfg_proc_rise,
    input  logic [PW-1:0] cfg_proc_fall,
    input  logic [PW-1:0] cfg_imem_rise,
    input  logic [PW-1:0] cfg_imem_fall,
    input  logic [PW-1:0] cfg_dmem_rise,
    input  logic [PW-1:0] cfg_dmem_fall,
    input  logic [PW-1:0] cfg_reg_rise,
    input  logic [PW-1:0] cfg_reg_fall,
    output logic          processor_clock,
    output logic          imem_clock,
    output logic          dmem_clock,
    output logic          regfile_clock,
    output logic [PW-1:0] phase,
    output logic          period_start,
    output logic          busy,
    output logic          step_ack
`ifdef CLOCK_PHASE_CYCLE_COUNT_EN
    ,
    output logic [31:0]   cycle_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, STEP} state_t;

    localparam logic [PW-1:0] LAST = PW'(PERIOD - 1);

    state_t        state, state_n;
    logic [PW-1:0] phase_n;
    logic          load_cfg;
    logic          wrap;
    logic          ack_n;
    logic          busy_n;

    logic [PW-1:0] sh_proc_rise, sh_proc_fall, sh_imem_rise, sh_imem_fall;
    logic [PW-1:0] sh_dmem_rise, sh_dmem_fall, sh_reg_rise, sh_reg_fall;
    logic [PW-1:0] pr_n, pf_n, ir_n, if_n, dr_n, df_n, rr_n, rf_n;

    // A rise value outside the period never fires, so the output never goes
    // high; an out-of-range fall simply never ends the window within a period.
    function automatic logic in_window(input logic [PW-1:0] r,
                                       input logic [PW-1:0] f,
                                       input logic [PW-1:0] p);
        logic hi;
        if (int'(r) >= PERIOD || r == f)
            hi = 1'b0;
        else if (r < f)
            hi = (p >= r) && (p < f);
        else
            hi = (p >= r) || (p < f);
        return hi;
    endfunction

    // Next state / next phase; shadow reload only in IDLE or at period end.
    always_comb begin
        state_n  = state;
        phase_n  = phase;
        load_cfg = 1'b0;
        wrap     = 1'b0;
        ack_n    = 1'b0;
        case (state)
            IDLE: begin
                phase_n  = '0;
                load_cfg = 1'b1;
                if (run)
                    state_n = RUN;
                else if (step_req)
                    state_n = STEP;
            end
            RUN, STEP: begin
                if (phase == LAST) begin
                    phase_n  = '0;
                    load_cfg = 1'b1;
                    wrap     = 1'b1;
                    if (state == STEP) begin
                        state_n = IDLE;
                        ack_n   = 1'b1;
                    end else if (!run) begin
                        state_n = IDLE;
                    end
                end else begin
                    phase_n = phase + 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                phase_n = '0;
            end
        endcase
    end

    assign pr_n   = load_cfg ? cfg_proc_rise : sh_proc_rise;
    assign pf_n   = load_cfg ? cfg_proc_fall : sh_proc_fall;
    assign ir_n   = load_cfg ? cfg_imem_rise : sh_imem_rise;
    assign if_n   = load_cfg ? cfg_imem_fall : sh_imem_fall;
    assign dr_n   = load_cfg ? cfg_dmem_rise : sh_dmem_rise;
    assign df_n   = load_cfg ? cfg_dmem_fall : sh_dmem_fall;
    assign rr_n   = load_cfg ? cfg_reg_rise  : sh_reg_rise;
    assign rf_n   = load_cfg ? cfg_reg_fall  : sh_reg_fall;
    assign busy_n = (state_n != IDLE);

    // State, phase, shadow config and registered outputs, all from next values.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            phase           <= '0;
            sh_proc_rise    <= '0;
            sh_proc_fall    <= '0;
            sh_imem_rise    <= '0;
            sh_imem_fall    <= '0;
            sh_dmem_rise    <= '0;
            sh_dmem_fall    <= '0;
            sh_reg_rise     <= '0;
            sh_reg_fall     <= '0;
            processor_clock <= 1'b0;
            imem_clock      <= 1'b0;
            dmem_clock      <= 1'b0;
            regfile_clock   <= 1'b0;
            period_start    <= 1'b0;
            busy            <= 1'b0;
            step_ack        <= 1'b0;
        end else begin
            state           <= state_n;
            phase           <= phase_n;
            sh_proc_rise    <= pr_n;
            sh_proc_fall    <= pf_n;
            sh_imem_rise    <= ir_n;
            sh_imem_fall    <= if_n;
            sh_dmem_rise    <= dr_n;
            sh_dmem_fall    <= df_n;
            sh_reg_rise     <= rr_n;
            sh_reg_fall     <= rf_n;
            processor_clock <= busy_n && in_window(pr_n, pf_n, phase_n);
            imem_clock      <= busy_n && in_window(ir_n, if_n, phase_n);
            dmem_clock      <= busy_n && in_window(dr_n, df_n, phase_n);
            regfile_clock   <= busy_n && in_window(rr_n, rf_n, phase_n);
            period_start    <= busy_n && (phase_n == '0);
            busy            <= busy_n;
            step_ack        <= ack_n;
        end
    end

`ifdef CLOCK_PHASE_CYCLE_COUNT_EN
    // Completed-period counter, free-wrapping at 2^32.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset)
            cycle_count <= '0;
        else if (wrap)
            cycle_count <= cycle_count + 32'd1;
    end
`endif

endmodule
